pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces fixed-width, enable-driven inter-stage registers (IF/ID, ID/EX, ...) with one generic block. Backpressure is absorbed without a combinational ready path. Flush inserts a configurable bubble value, and a saturating stall counter supports performance analysis.

---
 rtl/pipe_stage_skid_if.sv | 24 ++
 rtl/pipe_stage_skid.sv | 103 ++++++++++
 tb/tb_pipe_stage_skid.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// A beat moves on a side when its valid and ready are both high at the rising clock edge.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 96
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // The stage itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    // The environment around the stage: upstream producer plus downstream consumer.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a two-entry skid buffer, flush-to-bubble and a saturating stall counter.
// in_ready and out_valid are decoded from the registered state only, so no combinational ready path exists.
module pipe_stage_skid #(
    parameter int                DATA_W      = 96,
    parameter logic [DATA_W-1:0] BUBBLE      = {DATA_W{1'b0}},
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CLR,
    pipe_stage_skid_if.slave       bus,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    // Encoding equals the number of held beats, so occupancy doubles as the state debug view.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_W-1:0]      r_main;
    logic [DATA_W-1:0]      r_skid;
    logic [DATA_W-1:0]      w_main_next;
    logic [DATA_W-1:0]      w_skid_next;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_stall;

    assign bus.out_valid = (r_state != EMPTY);
    assign bus.in_ready  = (r_state != TWO);
    assign bus.out_data  = r_main;
    assign occupancy     = r_state;
    assign stall_cnt     = r_stall_cnt;

    assign w_in_fire  = bus.in_valid & bus.in_ready;
    assign w_out_fire = bus.out_valid & bus.out_ready;
    assign w_stall    = bus.out_valid & ~bus.out_ready;

    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = ONE;
                    w_main_next  = bus.in_data;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_next = bus.in_data;
                end else if (w_in_fire) begin
                    w_state_next = TWO;
                    w_skid_next  = bus.in_data;
                end else if (w_out_fire) begin
                    w_state_next = EMPTY;
                    w_main_next  = BUBBLE;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain of MAIN can happen.
                if (w_out_fire) begin
                    w_state_next = ONE;
                    w_main_next  = r_skid;
                    w_skid_next  = BUBBLE;
                end
            end
            default: begin
                w_state_next = EMPTY;
                w_main_next  = BUBBLE;
                w_skid_next  = BUBBLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= EMPTY;
            r_main      <= BUBBLE;
            r_skid      <= BUBBLE;
            r_stall_cnt <= '0;
        end else begin
            // Counter keeps running through a flush; only reset clears it.
            if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (CLR) begin
                r_state <= EMPTY;
                r_main  <= BUBBLE;
                r_skid  <= BUBBLE;
            end else begin
                r_state <= w_state_next;
                r_main  <= w_main_next;
                r_skid  <= w_skid_next;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboard-checked stimulus for pipe_stage_skid: reset, streaming, backpressure, flush,
// stall-counter saturation on a narrow instance, and a randomised run against a queue model.
module tb_pipe_stage_skid;
    localparam int W  = 96;
    localparam int W2 = 8;

    logic CLK;
    logic RST;
    logic CLR;
    logic RST2;
    logic CLR2;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [1:0]  occupancy2;
    logic [2:0]  stall_cnt2;

    int n_cmp;
    int n_err;

    logic [W-1:0] exp_q[$];
    logic [15:0]  m_stall;

    pipe_stage_skid_if #(.DATA_W(W))  bus();
    pipe_stage_skid_if #(.DATA_W(W2)) bus2();

    pipe_stage_skid #(.DATA_W(W), .STALL_CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .bus(bus.slave),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(W2), .BUBBLE(8'hA5), .STALL_CNT_W(3)) dut2 (
        .CLK(CLK), .RST(RST2), .CLR(CLR2), .bus(bus2.slave),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic in_f;
        logic out_f;
        n_cmp = 0;
        n_err = 0;

        RST = 1'b1; CLR = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 96'h5; bus.out_ready = 1'b0;
        RST2 = 1'b1; CLR2 = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
        step();
        step();

        // Reset
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst2_out_data", bus2.out_data, 96'hA5);
        check_eq("rst2_occupancy", occupancy2, 0);

        // Streaming at full rate
        RST = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(i);
            step();
            check_eq($sformatf("stream_data_%0d", i), bus.out_data, W'(i));
            check_eq($sformatf("stream_valid_%0d", i), bus.out_valid, 1);
            check_eq($sformatf("stream_in_ready_%0d", i), bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        step();
        check_eq("stream_drain_valid", bus.out_valid, 0);
        check_eq("stream_drain_data", bus.out_data, 0);
        check_eq("stream_drain_occ", occupancy, 0);
        check_eq("stream_stall_cnt", stall_cnt, 0);

        // Backpressure: A in MAIN, B into SKID, C held upstream
        bus.in_valid = 1'b1; bus.in_data = 96'hA;
        step();
        check_eq("bp_a_main", bus.out_data, 96'hA);
        bus.out_ready = 1'b0; bus.in_data = 96'hB;
        step();
        check_eq("bp_occ_two", occupancy, 2);
        check_eq("bp_in_ready_low", bus.in_ready, 0);
        check_eq("bp_a_held", bus.out_data, 96'hA);
        bus.in_data = 96'hC;
        step();
        check_eq("bp_occ_still_two", occupancy, 2);
        check_eq("bp_a_still", bus.out_data, 96'hA);
        bus.out_ready = 1'b1;
        step();
        check_eq("bp_b_out", bus.out_data, 96'hB);
        check_eq("bp_occ_one", occupancy, 1);
        check_eq("bp_in_ready_back", bus.in_ready, 1);
        step();
        check_eq("bp_c_out", bus.out_data, 96'hC);
        check_eq("bp_c_occ", occupancy, 1);
        bus.in_valid = 1'b0;
        step();
        check_eq("bp_empty", occupancy, 0);
        check_eq("bp_stall_cnt", stall_cnt, 2);

        // Flush with a full stage and a beat offered in the flush cycle
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 96'h11;
        step();
        bus.in_data = 96'h22;
        step();
        check_eq("fl_occ_two", occupancy, 2);
        check_eq("fl_main_11", bus.out_data, 96'h11);
        CLR = 1'b1; bus.in_data = 96'h33;
        step();
        CLR = 1'b0; bus.in_valid = 1'b0;
        check_eq("fl_occ", occupancy, 0);
        check_eq("fl_out_valid", bus.out_valid, 0);
        check_eq("fl_out_data", bus.out_data, 0);
        check_eq("fl_in_ready", bus.in_ready, 1);
        check_eq("fl_stall_cnt", stall_cnt, 4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fl_no_33", bus.out_valid, 0);
        end

        // Saturation on the 3-bit counter instance
        RST2 = 1'b0;
        bus2.in_valid = 1'b1; bus2.in_data = 8'h3C;
        step();
        bus2.in_valid = 1'b0;
        check_eq("sat_main", bus2.out_data, 96'h3C);
        for (int i = 1; i <= 10; i++) begin
            step();
            check_eq($sformatf("sat_cnt_%0d", i), stall_cnt2, (i > 7) ? 7 : i);
        end
        RST2 = 1'b1;
        step();
        check_eq("sat_rst_cnt", stall_cnt2, 0);
        check_eq("sat_rst_data", bus2.out_data, 96'hA5);
        check_eq("sat_rst_occ", occupancy2, 0);

        // Random traffic against the queue model
        m_stall = 16'd4;
        for (int c = 0; c < 10000; c++) begin
            check_eq("rnd_valid", bus.out_valid, W'(exp_q.size() != 0));
            check_eq("rnd_occ", occupancy, W'(exp_q.size()));
            check_eq("rnd_in_ready", bus.in_ready, W'(exp_q.size() < 2));
            if (exp_q.size() != 0) check_eq("rnd_data", bus.out_data, exp_q[0]);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = {$urandom, $urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            if ((c % 64) == 0) begin
                bus.out_ready = ~bus.out_ready;
                #1;
                check_eq("rnd_ready_comb", bus.in_ready, W'(exp_q.size() < 2));
                bus.out_ready = ~bus.out_ready;
                #1;
            end
            out_f = (exp_q.size() != 0) && bus.out_ready;
            in_f  = bus.in_valid && (exp_q.size() < 2);
            if ((exp_q.size() != 0) && !bus.out_ready && (m_stall != 16'hFFFF)) m_stall++;
            if (out_f) void'(exp_q.pop_front());
            if (in_f) exp_q.push_back(bus.in_data);
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (exp_q.size() != 0) begin
                check_eq("drain_data", bus.out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            step();
        end
        check_eq("drain_model_empty", W'(exp_q.size()), 0);
        check_eq("drain_occ", occupancy, 0);
        check_eq("rnd_stall_cnt", stall_cnt, m_stall);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
